// File: rtl/uart_reg_ctrl_if.sv
// Bus between the UART command sequencer and its UART/register-file peers.
// Carries rx byte stream, register strobes, tx handshake and error flags.
interface uart_reg_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       clr_err;
  logic       err_timeout;
  logic       err_overrun;

  modport master (
    output rx_valid, rx_data, reg_rdata,
    output tx_ready, clr_err,
    input  reg_addr, reg_wdata,
    input  reg_wr_en, reg_rd_en,
    input  tx_valid, tx_data, busy,
    input  err_timeout, err_overrun
  );

  modport slave (
    input  rx_valid, rx_data, reg_rdata,
    input  tx_ready, clr_err,
    output reg_addr, reg_wdata,
    output reg_wr_en, reg_rd_en,
    output tx_valid, tx_data, busy,
    output err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_reg_ctrl.sv
// UART command sequencer: parses rx bytes into register writes/reads.
// Ports: clk, resetn (async low), bus (slave side of uart_reg_ctrl_if).
module uart_reg_ctrl #(
  parameter int CLK_HZ        = 50000000,
  parameter int BIT_RATE      = 11520,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic            clk,
  input logic            resetn,
  uart_reg_ctrl_if.slave bus
);

  localparam int TIMEOUT_CYC =
    TIMEOUT_BYTES * 10 * (CLK_HZ / BIT_RATE);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VAL,
    WRITE,
    READ,
    CAPTURE,
    TX
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          to_evt;
  logic          ov_evt;

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    to_evt = 1'b0;
    ov_evt = 1'b0;
    if (state == WAIT_VAL && !bus.rx_valid && cnt == CNT_LAST)
      to_evt = 1'b1;
    if (bus.rx_valid &&
        (state == WRITE || state == READ ||
         state == CAPTURE || state == TX))
      ov_evt = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.reg_addr    <= '0;
      bus.reg_wdata   <= '0;
      bus.reg_wr_en   <= 1'b0;
      bus.reg_rd_en   <= 1'b0;
      bus.tx_valid    <= 1'b0;
      bus.tx_data     <= '0;
      bus.busy        <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;

      // Set beats clear when both land together.
      if (to_evt)
        bus.err_timeout <= 1'b1;
      else if (bus.clr_err)
        bus.err_timeout <= 1'b0;
      if (ov_evt)
        bus.err_overrun <= 1'b1;
      else if (bus.clr_err)
        bus.err_overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            bus.reg_addr <= bus.rx_data[6:0];
            bus.busy     <= 1'b1;
            if (bus.rx_data[7]) begin
              state <= WAIT_VAL;
              cnt   <= '0;
            end else begin
              state         <= READ;
              bus.reg_rd_en <= 1'b1;
            end
          end
        end
        WAIT_VAL: begin
          if (bus.rx_valid) begin
            bus.reg_wdata <= bus.rx_data;
            bus.reg_wr_en <= 1'b1;
            state         <= WRITE;
          end else if (to_evt) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          bus.tx_data  <= bus.reg_rdata;
          bus.tx_valid <= 1'b1;
          state        <= TX;
        end
        TX: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: directed byte stream, register-file model,
// transaction-level reference model compared every cycle.
module tb_uart_reg_ctrl;

  localparam int T = 400;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  uart_reg_ctrl_if bus ();

  uart_reg_ctrl #(
    .CLK_HZ       (115200),
    .BIT_RATE     (11520),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file attached to the sequencer
  logic [7:0] mem [128];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  logic [6:0] rd_log [$];

  always @(posedge clk) begin
    if (bus.reg_wr_en) begin
      mem[bus.reg_addr] <= bus.reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.reg_rd_en) begin
      bus.reg_rdata <= mem[bus.reg_addr];
      rd_cnt <= rd_cnt + 1;
      rd_log.push_back(bus.reg_addr);
    end
    if (bus.tx_valid && bus.tx_ready)
      tx_cnt <= tx_cnt + 1;
  end

  // reference model: pending-command bookkeeping
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_txd;
  logic [7:0] m_mem [128];
  bit         m_wait;
  bit         m_wr;
  int         m_rd;
  int         m_age;
  bit         m_eto;
  bit         m_eov;

  task automatic model_reset();
    m_addr  = '0;
    m_wdata = '0;
    m_txd   = '0;
    m_wait  = 0;
    m_wr    = 0;
    m_rd    = -1;
    m_age   = 0;
    m_eto   = 0;
    m_eov   = 0;
  endtask

  task automatic model_step();
    bit set_to;
    bit set_ov;
    set_to = 0;
    set_ov = 0;
    if (m_wr) begin
      m_mem[m_addr] = m_wdata;
      m_wr = 0;
      set_ov = bus.rx_valid;
    end else if (m_rd >= 0) begin
      set_ov = bus.rx_valid;
      if (m_rd < 2) begin
        m_rd++;
        if (m_rd == 2)
          m_txd = m_mem[m_addr];
      end else if (bus.tx_ready) begin
        m_rd = -1;
      end
    end else if (m_wait) begin
      if (bus.rx_valid) begin
        m_wdata = bus.rx_data;
        m_wait  = 0;
        m_wr    = 1;
      end else if (m_age == T - 1) begin
        m_wait = 0;
        set_to = 1;
      end else begin
        m_age++;
      end
    end else if (bus.rx_valid) begin
      m_addr = bus.rx_data[6:0];
      if (bus.rx_data[7]) begin
        m_wait = 1;
        m_age  = 0;
      end else begin
        m_rd = 0;
      end
    end
    m_eto = set_to ? 1'b1 : (bus.clr_err ? 1'b0 : m_eto);
    m_eov = set_ov ? 1'b1 : (bus.clr_err ? 1'b0 : m_eov);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn)
        model_reset();
      else
        model_step();
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("reg_addr", 32'(bus.reg_addr), 32'(m_addr));
      chk("reg_wdata", 32'(bus.reg_wdata), 32'(m_wdata));
      chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(m_wr));
      chk("reg_rd_en", 32'(bus.reg_rd_en), 32'(m_rd == 0));
      chk("tx_valid", 32'(bus.tx_valid), 32'(m_rd == 2));
      chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
      chk("busy", 32'(bus.busy),
          32'(m_wait || m_wr || m_rd >= 0));
      chk("err_timeout", 32'(bus.err_timeout), 32'(m_eto));
      chk("err_overrun", 32'(bus.err_overrun), 32'(m_eov));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  logic [7:0] seq [7];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    bus.clr_err  = 1'b0;
    resetn       = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i]   = 8'(i) ^ 8'h5A;
      m_mem[i] = 8'(i) ^ 8'h5A;
    end
    tick(3);
    resetn = 1'b1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.reg_addr), 0);

    // write 0x05 <= 0x3C
    send(8'h85);
    chk("wr_wait_busy", 32'(bus.busy), 1);
    send(8'h3C);
    chk("wr_en", 32'(bus.reg_wr_en), 1);
    chk("wr_addr", 32'(bus.reg_addr), 32'h05);
    chk("wr_data", 32'(bus.reg_wdata), 32'h3C);
    tick(1);
    chk("wr_busy_done", 32'(bus.busy), 0);
    chk("wr_cnt1", 32'(wr_cnt), 1);
    chk("mem05", 32'(mem[5]), 32'h3C);

    // read back 0x05 with stalled transmitter
    send(8'h05);
    chk("rd_en", 32'(bus.reg_rd_en), 1);
    chk("rd_addr", 32'(bus.reg_addr), 32'h05);
    tick(2);
    chk("tx_valid", 32'(bus.tx_valid), 1);
    chk("tx_data", 32'(bus.tx_data), 32'h3C);
    tick(10);
    chk("tx_hold_valid", 32'(bus.tx_valid), 1);
    chk("tx_hold_data", 32'(bus.tx_data), 32'h3C);
    bus.tx_ready = 1'b1;
    tick(1);
    bus.tx_ready = 1'b0;
    chk("tx_drop", 32'(bus.tx_valid), 0);
    chk("rd_busy_done", 32'(bus.busy), 0);

    // timeout waiting for value byte
    send(8'h81);
    tick(T - 1);
    chk("to_not_yet", 32'(bus.err_timeout), 0);
    chk("to_busy", 32'(bus.busy), 1);
    tick(1);
    chk("to_set", 32'(bus.err_timeout), 1);
    chk("to_idle", 32'(bus.busy), 0);
    chk("to_no_wr", 32'(wr_cnt), 1);
    send(8'h02);
    chk("to_rd_en", 32'(bus.reg_rd_en), 1);
    chk("to_rd_addr", 32'(bus.reg_addr), 32'h02);
    bus.tx_ready = 1'b1;
    tick(3);
    bus.tx_ready = 1'b0;
    chk("to_tx_cnt", 32'(tx_cnt), 2);

    // value byte exactly on the expiry cycle wins
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    chk("clr_to", 32'(bus.err_timeout), 0);
    send(8'h83);
    tick(T - 1);
    send(8'h44);
    chk("edge_wr_en", 32'(bus.reg_wr_en), 1);
    chk("edge_wdata", 32'(bus.reg_wdata), 32'h44);
    chk("edge_no_to", 32'(bus.err_timeout), 0);
    tick(1);
    chk("edge_wr_cnt", 32'(wr_cnt), 2);

    // overrun during TX, coinciding with clr_err
    send(8'h10);
    tick(2);
    bus.clr_err = 1'b1;
    send(8'hAA);
    bus.clr_err = 1'b0;
    chk("ov_set", 32'(bus.err_overrun), 1);
    chk("ov_tx_valid", 32'(bus.tx_valid), 1);
    chk("ov_tx_data", 32'(bus.tx_data), 32'h4A);
    chk("ov_rd_cnt", 32'(rd_cnt), 3);
    chk("ov_wr_cnt", 32'(wr_cnt), 2);
    bus.tx_ready = 1'b1;
    tick(1);
    bus.tx_ready = 1'b0;
    chk("ov_sticky", 32'(bus.err_overrun), 1);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    chk("ov_clr", 32'(bus.err_overrun), 0);

    // reset in the middle of a write
    send(8'h87);
    tick(2);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_addr", 32'(bus.reg_addr), 0);
    tick(1);
    resetn = 1'b1;
    send(8'h11);
    chk("rst_rd_en", 32'(bus.reg_rd_en), 1);
    chk("rst_rd_addr", 32'(bus.reg_addr), 32'h11);
    bus.tx_ready = 1'b1;
    tick(3);
    bus.tx_ready = 1'b0;
    tick(1);
    chk("mem07_kept", 32'(mem[7]), 32'h5D);
    chk("rst_wr_cnt", 32'(wr_cnt), 2);

    // back-to-back reads
    seq = '{8'h41, 8'h31, 8'h42, 8'h32,
            8'h43, 8'h33, 8'h00};
    rd_log.delete();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      tick(3);
    end
    bus.tx_ready = 1'b0;
    tick(1);
    chk("b2b_reads", 32'(rd_log.size()), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < rd_log.size())
        chk("b2b_addr", 32'(rd_log[i]), 32'(seq[i]));
    end
    chk("b2b_tx_cnt", 32'(tx_cnt), 11);
    chk("b2b_no_ov", 32'(bus.err_overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the register file in the UART top level. It parses the incoming byte stream into register commands. A write is an address byte with bit7=1 followed by a value byte. A read is an address byte with bit7=0. The block issues the register-file strobes and returns read data through the UART transmit handshake. It also detects inter-byte timeouts and byte overruns.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BIT_RATE, 11520, UART line bit rate
TIMEOUT_BYTES, 4, max gap between address and value byte, in UART frame times (10 bits each)
TIMEOUT_CYC, TIMEOUT_BYTES*10*(CLK_HZ/BIT_RATE), derived; default 173600 (CLK_HZ/BIT_RATE integer = 4340)

Ports:
clk        in   1  system clock, rising edge
resetn     in   1  asynchronous active-low reset
rx_valid   in   1  one-cycle pulse: rx_data holds a received byte
rx_data    in   8  received byte
reg_addr   out  7  register address, held from address byte until next command
reg_wdata  out  8  write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rdata  in   8  read data, valid exactly 1 cycle after reg_rd_en
tx_valid   out  1  response byte valid
tx_data    out  8  response byte
tx_ready   in   1  transmitter accepts byte when tx_valid & tx_ready
busy       out  1  high in any state other than IDLE
clr_err    in   1  synchronous clear of sticky error flags
err_timeout out 1  sticky: value byte not received within TIMEOUT_CYC
err_overrun out 1  sticky: byte received while unable to accept

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0, including reg_addr, reg_wdata, tx_data, strobes, flags. Timeout counter 0.
- States: IDLE, WAIT_VAL, WRITE, READ, CAPTURE, TX.
- IDLE:
  - rx_valid with rx_data[7]=1: reg_addr<=rx_data[6:0]; go to WAIT_VAL; clear counter.
  - rx_valid with rx_data[7]=0: reg_addr<=rx_data[6:0]; go to READ.
- WAIT_VAL:
  - Counter increments each cycle.
  - rx_valid: reg_wdata<=rx_data; go to WRITE. Any byte value is accepted, including 0x00 and bytes with bit7=1.
  - Counter reaching TIMEOUT_CYC-1 without rx_valid: err_timeout<=1; go to IDLE; no write is issued.
  - rx_valid on the same cycle as expiry: the byte wins; no timeout.
- WRITE: reg_wr_en=1 for exactly this cycle; go to IDLE. Write latency is 1 cycle from the value byte's rx_valid to reg_wr_en.
- READ: reg_rd_en=1 for this cycle; go to CAPTURE.
- CAPTURE: tx_data<=reg_rdata; go to TX.
- TX:
  - tx_valid=1; tx_data stable until handshake.
  - On tx_valid & tx_ready: go to IDLE. tx_valid drops the following cycle.
  - No timeout in TX; the block waits indefinitely for tx_ready.
- Overrun: rx_valid in WRITE, READ, CAPTURE or TX sets err_overrun; the byte is dropped; the state is unaffected.
- clr_err=1: both flags <=0. If an error event occurs in the same cycle, the set wins.
- reg_addr and reg_wdata are not cleared between commands.
- Reset asserted mid-command: return to IDLE immediately. tx_valid and strobes drop asynchronously. Any partial command is discarded.

Test Plan:
- Write: rx bytes 0x85 then 0x3C -> exactly one reg_wr_en pulse with reg_addr=0x05, reg_wdata=0x3C, one cycle after the second rx_valid; busy back to 0 on the next cycle.
- Read: reg file addr 0x05=0x3C; rx byte 0x05 -> reg_rd_en one cycle later; tx_valid with tx_data=0x3C; hold tx_ready=0 for 10 cycles -> tx_valid and tx_data stable; tx_ready=1 -> tx_valid drops the next cycle.
- Timeout: rx 0x81, then no byte for 173600 cycles -> err_timeout=1, no reg_wr_en; next rx 0x02 is treated as a read of addr 0x02.
- Overrun: read of 0x10 with tx_ready=0; inject rx 0xAA in TX -> err_overrun=1, no strobe; after the handshake, clr_err pulse -> flag 0.
- Reset mid-write: rx 0x87, assert resetn=0 in WAIT_VAL, release, rx 0x11 -> treated as a read of 0x11, no write to 0x07.
- Back-to-back: the byte sequence from the UART top bench ("A","1","B","2",...,0x00) driven through the rx model -> reads at addresses 0x41, 0x31, ..., 0x00, one tx response each, with tx_ready tied to 1.
